backing_mem_responder: RTL and testbench

BACKING_MEM_RESPONDER -- requirements
Module: backing_mem_responder

---
 rtl/backing_mem_responder.sv | 138 +++++++++++++
 tb/tb_backing_mem_responder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/backing_mem_responder.sv
// Fixed-latency line-granular backing memory for a cache refill/writeback port.
// One request in flight at a time; completion is signalled by a single m_done pulse.
module backing_mem_responder #(
  parameter int unsigned Number_of_lines = 256,
  parameter int unsigned Block_size      = 64,
  parameter int unsigned Latency         = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [63:0]             m_addr,
  input  logic [Block_size*8-1:0] m_write_data,
  input  logic                    m_read_en,
  input  logic                    m_write_en,
  output logic [Block_size*8-1:0] m_read_data,
  output logic                    m_busy,
  output logic                    m_done,
  output logic                    m_err
);

  localparam int unsigned IDX_W  = $clog2(Number_of_lines);
  localparam int unsigned LINE_W = Block_size * 8;
  localparam int unsigned OFF_W  = 6;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(Latency - 1);
  localparam bit DIRECT_DONE = (Latency <= 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [IDX_W-1:0]  idx_q;
  logic              wr_q;
  logic [LINE_W-1:0] wdata_q;

  logic              accept_c;
  logic              finish_c;
  logic [IDX_W-1:0]  op_idx_c;
  logic              op_wr_c;
  logic [LINE_W-1:0] op_wdata_c;

  logic [LINE_W-1:0] mem [Number_of_lines];

  // Offset and aliasing bits above the index are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m_addr[63:IDX_W+OFF_W], m_addr[OFF_W-1:0]};

  // Next-state and control decode.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept_c   = 1'b0;
    finish_c   = 1'b0;
    unique case (state)
      IDLE: begin
        if (m_read_en || m_write_en) begin
          accept_c = 1'b1;
          cnt_next = CNT_LOAD;
          if (DIRECT_DONE) begin
            state_next = DONE;
            finish_c   = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          cnt_next   = '0;
          state_next = DONE;
          finish_c   = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // With single-cycle latency the operation completes on the accepting edge,
  // so the live request inputs stand in for the not-yet-captured copies.
  always_comb begin
    op_idx_c   = idx_q;
    op_wr_c    = wr_q;
    op_wdata_c = wdata_q;
    if (state == IDLE) begin
      op_idx_c   = m_addr[OFF_W +: IDX_W];
      op_wr_c    = m_write_en;
      op_wdata_c = m_write_data;
    end
  end

  // State, captured request and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx_q       <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      m_busy      <= 1'b0;
      m_done      <= 1'b0;
      m_err       <= 1'b0;
      m_read_data <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      m_busy <= (state_next != IDLE);
      m_done <= (state_next == DONE);
      m_err  <= accept_c && m_read_en && m_write_en;
      if (accept_c) begin
        idx_q   <= m_addr[OFF_W +: IDX_W];
        wr_q    <= m_write_en;
        wdata_q <= m_write_data;
      end
      if (finish_c && !op_wr_c) begin
        m_read_data <= mem[op_idx_c];
      end
    end
  end

  // Storage is never cleared; a reset-aborted write must not land.
  always_ff @(posedge clk) begin
    if (rst && finish_c && op_wr_c) begin
      mem[op_idx_c] <= op_wdata_c;
    end
  end

endmodule

// File: tb/tb_backing_mem_responder.sv
// Directed bench for backing_mem_responder: Latency=4 instance for the table and
// corner sequences, Latency=1 instance for back-to-back held requests.
module tb_backing_mem_responder;

  logic         clk;
  logic         rst;
  logic [63:0]  addr4, addr1;
  logic [511:0] wdata4, wdata1;
  logic         rd4, wr4, rd1, wr1;
  logic [511:0] rdata4, rdata1;
  logic         busy4, done4, err4, busy1, done1, err1;

  int checks = 0;
  int errors = 0;

  backing_mem_responder #(.Number_of_lines(256), .Block_size(64), .Latency(4)) u4 (
    .clk(clk), .rst(rst), .m_addr(addr4), .m_write_data(wdata4),
    .m_read_en(rd4), .m_write_en(wr4), .m_read_data(rdata4),
    .m_busy(busy4), .m_done(done4), .m_err(err4)
  );

  backing_mem_responder #(.Number_of_lines(256), .Block_size(64), .Latency(1)) u1 (
    .clk(clk), .rst(rst), .m_addr(addr1), .m_write_data(wdata1),
    .m_read_en(rd1), .m_write_en(wr1), .m_read_data(rdata1),
    .m_busy(busy1), .m_done(done1), .m_err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [63:0]  addr;
    logic [511:0] wdata;
    logic [511:0] exp_rdata;
    logic         exp_err;
  } vec_t;

  vec_t vecs[9];

  localparam logic [511:0] PAT_A = {64{8'hA5}};
  localparam logic [511:0] PAT_D = {16{32'h1234_5678}};
  localparam logic [511:0] PAT_C = {64{8'h3C}};
  localparam logic [511:0] PAT_E = {8{64'hDEAD_BEEF_0BAD_F00D}};
  localparam logic [511:0] PAT_F = {64{8'hFF}};
  localparam logic [511:0] PAT_G = {64{8'h5A}};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_data(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_ctl(input string nm, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: busy/done/err got %b want %b", nm, act, exp);
    end
  endtask

  // One request on the Latency=4 instance, checked cycle by cycle until idle.
  task automatic txn(input logic rd_i, input logic wr_i, input logic [63:0] a,
                     input logic [511:0] d, input logic [511:0] exp_rd,
                     input logic exp_err, input string nm);
    rd4 = rd_i; wr4 = wr_i; addr4 = a; wdata4 = d;
    step();
    rd4 = 1'b0; wr4 = 1'b0; addr4 = 64'hFFC0; wdata4 = ~d;
    for (int k = 0; k <= 4; k++) begin
      chk_ctl($sformatf("%s cyc%0d", nm, k), {busy4, done4, err4},
              {k <= 3, k == 3, (k == 0) && exp_err});
      if (k < 4) step();
    end
    chk_data({nm, " rdata"}, rdata4, exp_rd);
  endtask

  initial begin
    int dones;

    vecs[0] = '{1'b0, 1'b1, 64'h40,   PAT_A, 512'h0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 64'h40,   PAT_F, PAT_A,  1'b0};
    vecs[2] = '{1'b1, 1'b0, 64'h4040, PAT_F, PAT_A,  1'b0};
    vecs[3] = '{1'b1, 1'b1, 64'h80,   PAT_D, PAT_A,  1'b1};
    vecs[4] = '{1'b1, 1'b0, 64'h80,   PAT_F, PAT_D,  1'b0};
    vecs[5] = '{1'b0, 1'b1, 64'hC0,   PAT_C, PAT_D,  1'b0};
    vecs[6] = '{1'b1, 1'b0, 64'hC3,   PAT_F, PAT_C,  1'b0};
    vecs[7] = '{1'b0, 1'b1, 64'h100,  PAT_E, PAT_C,  1'b0};
    vecs[8] = '{1'b1, 1'b0, 64'h100,  PAT_F, PAT_E,  1'b0};

    rst = 1'b0;
    rd4 = 1'b0; wr4 = 1'b0; addr4 = '0; wdata4 = '0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    step();
    rd4 = 1'b1;
    step();
    chk_ctl("reset u4 ctl", {busy4, done4, err4}, 3'b000);
    chk_data("reset u4 rdata", rdata4, 512'h0);
    chk_ctl("reset u1 ctl", {busy1, done1, err1}, 3'b000);
    chk_data("reset u1 rdata", rdata1, 512'h0);
    rd4 = 1'b0;
    rst = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
          vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
    end

    // Request pulsed during WAIT is dropped, not queued.
    rd4 = 1'b1; addr4 = 64'h40;
    step();
    rd4 = 1'b0;
    step();
    wr4 = 1'b1; addr4 = 64'h80; wdata4 = PAT_F;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      wr4 = 1'b0;
      if (done4) dones++;
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL ignored-req done count: got %0d want 1", dones);
    end
    chk_data("ignored-req rdata", rdata4, PAT_A);
    txn(1'b1, 1'b0, 64'h80, PAT_F, PAT_D, 1'b0, "after-ignored read80");

    // Reset two cycles into a write aborts it.
    wr4 = 1'b1; addr4 = 64'hC0; wdata4 = PAT_F;
    step();
    wr4 = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk_ctl("abort ctl", {busy4, done4, err4}, 3'b000);
    chk_data("abort rdata", rdata4, 512'h0);
    rst = 1'b1;
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (done4 || busy4) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL abort activity: got %0d busy/done cycles want 0", dones);
    end
    txn(1'b1, 1'b0, 64'hC0, PAT_F, PAT_C, 1'b0, "abort read C0");

    // Latency=1: write completes in one cycle, held read repeats every other cycle.
    wr1 = 1'b1; addr1 = 64'h40; wdata1 = PAT_G;
    step();
    chk_ctl("lat1 write done", {busy1, done1, err1}, 3'b110);
    wr1 = 1'b0; wdata1 = PAT_F;
    step();
    chk_ctl("lat1 write idle", {busy1, done1, err1}, 3'b000);
    rd1 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk_ctl($sformatf("lat1 held cyc%0d", k), {busy1, done1, err1},
              {k % 2 == 1, k % 2 == 1, 1'b0});
    end
    rd1 = 1'b0;
    step();
    chk_data("lat1 rdata", rdata1, PAT_G);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
